// File: rtl/viterbi_pkg.sv
// Shared definitions for the rate-1/2, K=3 convolutional encoder and its Viterbi decoder.
// Holds the trellis state type, the default generators, the encoder FSM enum and the branch function.
package viterbi_pkg;

    localparam int K = 3;

    typedef logic [K-2:0] state_t;

    localparam state_t S0 = 2'd0;
    localparam state_t S1 = 2'd1;
    localparam state_t S2 = 2'd2;
    localparam state_t S3 = 2'd3;

    localparam logic [K-1:0] G0_DEFAULT = 3'b111;
    localparam logic [K-1:0] G1_DEFAULT = 3'b101;

    typedef enum logic [1:0] {
        ENC_IDLE = 2'd0,
        ENC_DATA = 2'd1,
        ENC_TAIL = 2'd2,
        ENC_DONE = 2'd3
    } enc_fsm_t;

    // Symbol {g0, g1} for input u leaving state s; the register view is {u, s[1], s[0]}.
    function automatic logic [1:0] conv_branch(
        input logic           u,
        input state_t         s,
        input logic [K-1:0]   g0 = G0_DEFAULT,
        input logic [K-1:0]   g1 = G1_DEFAULT
    );
        logic [K-1:0] reg_v;
        reg_v = {u, s};
        return {^(g0 & reg_v), ^(g1 & reg_v)};
    endfunction

endpackage

// File: rtl/convolutional_encoder_if.sv
// Bit-in / symbol-out handshakes of the convolutional encoder.
// Both sides use valid/ready: a beat transfers on a rising edge where valid and ready are both high.
interface convolutional_encoder_if;

    logic       i_data_valid;
    logic       i_data_bit;
    logic       o_data_ready;
    logic [1:0] o_symbol;
    logic       o_symbol_valid;
    logic       i_symbol_ready;

    modport master (
        output i_data_valid,
        output i_data_bit,
        output i_symbol_ready,
        input  o_data_ready,
        input  o_symbol,
        input  o_symbol_valid
    );

    modport slave (
        input  i_data_valid,
        input  i_data_bit,
        input  i_symbol_ready,
        output o_data_ready,
        output o_symbol,
        output o_symbol_valid
    );

endinterface

// File: rtl/convolutional_encoder.sv
// Rate-1/2 K=3 convolutional encoder: encodes a FRAME_LEN-bit frame, then flushes two zero
// tail bits so the trellis ends in S0. One registered output symbol slot, no bubbles when ready.
module convolutional_encoder
    import viterbi_pkg::*;
#(
    parameter int           FRAME_LEN = 8,
    parameter logic [K-1:0] G0        = G0_DEFAULT,
    parameter logic [K-1:0] G1        = G1_DEFAULT
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    convolutional_encoder_if.slave  enc_if,
    output logic                    o_busy,
    output logic                    o_done,
    output enc_fsm_t                o_dbg_fsm,
    output state_t                  o_dbg_s
);

    localparam int               CNT_W    = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

    enc_fsm_t         state_q, state_d;
    state_t           s_q, s_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             tail_cnt_q, tail_cnt_d;
    logic [1:0]       sym_q, sym_d;
    logic             sym_valid_q, sym_valid_d;
    logic             done_q, done_d;

    logic slot_free;
    logic accept;
    logic tail_load;
    logic load;
    logic u;
    logic final_xfer;

    // The slot can be refilled in the same cycle its current symbol leaves.
    assign slot_free  = !sym_valid_q || enc_if.i_symbol_ready;
    assign accept     = (state_q == ENC_DATA) && enc_if.i_data_valid && slot_free;
    assign tail_load  = (state_q == ENC_TAIL) && slot_free;
    assign load       = accept || tail_load;
    assign u          = accept ? enc_if.i_data_bit : 1'b0;
    assign final_xfer = (state_q == ENC_DONE) && sym_valid_q && enc_if.i_symbol_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ENC_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ENC_IDLE: if (i_start)                              state_d = ENC_DATA;
            ENC_DATA: if (accept && (bit_cnt_q == LAST_BIT))    state_d = ENC_TAIL;
            ENC_TAIL: if (tail_load && tail_cnt_q)              state_d = ENC_DONE;
            ENC_DONE: if (final_xfer)                           state_d = ENC_IDLE;
            default:                                            state_d = ENC_IDLE;
        endcase
    end

    always_comb begin
        o_busy                = (state_q == ENC_DATA) || (state_q == ENC_TAIL);
        o_done                = done_q;
        o_dbg_fsm             = state_q;
        o_dbg_s               = s_q;
        enc_if.o_data_ready   = (state_q == ENC_DATA) && slot_free;
        enc_if.o_symbol       = sym_q;
        enc_if.o_symbol_valid = sym_valid_q;
    end

    always_comb begin
        s_d         = s_q;
        bit_cnt_d   = bit_cnt_q;
        tail_cnt_d  = tail_cnt_q;
        sym_d       = sym_q;
        sym_valid_d = sym_valid_q;
        done_d      = final_xfer;

        if ((state_q == ENC_IDLE) && i_start) begin
            s_d        = S0;
            bit_cnt_d  = '0;
            tail_cnt_d = 1'b0;
        end

        if (load) begin
            sym_d       = conv_branch(u, s_q, G0, G1);
            sym_valid_d = 1'b1;
            s_d         = {u, s_q[1]};
        end else if (enc_if.i_symbol_ready) begin
            sym_valid_d = 1'b0;
        end

        if (accept) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
        if (tail_load) begin
            tail_cnt_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s_q         <= S0;
            bit_cnt_q   <= '0;
            tail_cnt_q  <= 1'b0;
            sym_q       <= 2'b00;
            sym_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            s_q         <= s_d;
            bit_cnt_q   <= bit_cnt_d;
            tail_cnt_q  <= tail_cnt_d;
            sym_q       <= sym_d;
            sym_valid_q <= sym_valid_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_convolutional_encoder.sv
// Bench for convolutional_encoder: directed frames plus randomized frames, gaps and back-pressure,
// scored against a tap-window model of the (7,5) code with zero-tail termination.
module tb_convolutional_encoder;
    import viterbi_pkg::*;

    localparam int         FL     = 4;
    localparam int         NSYM   = FL + 2;
    localparam int         TMO    = 200;
    localparam logic [2:0] TB_G0  = 3'b111;
    localparam logic [2:0] TB_G1  = 3'b101;

    // ---------------- clock / reset ----------------
    logic     clk   = 1'b0;
    logic     rst_n = 1'b0;
    logic     start = 1'b0;
    logic     busy;
    logic     done;
    enc_fsm_t dbg_fsm;
    state_t   dbg_s;
    int       cyc   = 0;

    convolutional_encoder_if bus();

    convolutional_encoder #(
        .FRAME_LEN (FL),
        .G0        (TB_G0),
        .G1        (TB_G1)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_start   (start),
        .enc_if    (bus),
        .o_busy    (busy),
        .o_done    (done),
        .o_dbg_fsm (dbg_fsm),
        .o_dbg_s   (dbg_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [1:0] exp_q[$];
    int         checks   = 0;
    int         failures = 0;
    int         ready_mode = 0;   // 0: always ready, 1: toggle 1/0, 2: random

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void fail_event(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event did not occur within %0d cycles (cycle %0d)", name, TMO, cyc);
    endfunction

    // Reference: symbol i sees taps {u[i], u[i-1], u[i-2]} of the zero-padded, zero-tailed frame.
    task automatic push_model(input logic [FL-1:0] bits);
        logic [FL+3:0] p;
        logic [2:0]    w;
        p = {2'b00, bits, 2'b00};
        for (int i = 0; i < NSYM; i++) begin
            w = {p[i+2], p[i+1], p[i]};
            exp_q.push_back({^(w & TB_G0), ^(w & TB_G1)});
        end
    endtask

    task automatic push_golden_1011();
        exp_q.push_back(2'b11);
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b11);
    endtask

    // ---------------- downstream ready driver ----------------
    initial begin
        bus.i_symbol_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.i_symbol_ready = 1'b1;
                1:       bus.i_symbol_ready = ~bus.i_symbol_ready;
                default: bus.i_symbol_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- monitor ----------------
    logic       hold_prev = 1'b0;
    logic [1:0] hold_sym  = 2'b00;
    int         mon_cnt   = 0;
    logic       done_exp  = 1'b0;
    int         done_cyc  = 0;
    logic       first_pending = 1'b0;
    logic       b2b_armed = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev     = 1'b0;
            mon_cnt       = 0;
            done_exp      = 1'b0;
            first_pending = 1'b0;
        end else begin
            check("o_done", 32'(done), 32'(done_exp));
            if (done_exp) begin
                check("fsm_idle_in_done_cycle", 32'(dbg_fsm), 32'(ENC_IDLE));
                check("final_state_S0", 32'(dbg_s), 32'(S0));
                check("busy_low_in_done_cycle", 32'(busy), 32'd0);
                done_cyc      = cyc;
                first_pending = 1'b1;
            end
            done_exp = 1'b0;

            if (hold_prev) begin
                check("held_valid", 32'(bus.o_symbol_valid), 32'd1);
                check("held_symbol", 32'(bus.o_symbol), 32'(hold_sym));
            end

            if (bus.o_symbol_valid && first_pending) begin
                if (b2b_armed) begin
                    check("b2b_first_symbol_latency", 32'(cyc - done_cyc), 32'd2);
                    b2b_armed = 1'b0;
                end
                first_pending = 1'b0;
            end

            if (bus.o_symbol_valid && bus.i_symbol_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_symbol: got %b, expected no symbol (cycle %0d)", bus.o_symbol, cyc);
                end else begin
                    check("symbol", 32'(bus.o_symbol), 32'(exp_q.pop_front()));
                end
                mon_cnt++;
                if (mon_cnt == NSYM) begin
                    mon_cnt  = 0;
                    done_exp = 1'b1;
                end
            end

            hold_prev = bus.o_symbol_valid && !bus.i_symbol_ready;
            hold_sym  = bus.o_symbol;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_bit(input logic b, input logic st);
        bit ok;
        ok = 1'b0;
        bus.i_data_valid = 1'b1;
        bus.i_data_bit   = b;
        start            = st;
        for (int t = 0; t < TMO; t++) begin
            @(negedge clk);
            if (bus.o_data_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.i_data_valid = 1'b0;
        start            = 1'b0;
        if (!ok) fail_event("data_handshake");
    endtask

    task automatic send_frame(input logic [FL-1:0] bits, input int gap, input bit start_mid,
                              input bit b2b, input bit use_model);
        if (use_model) push_model(bits);
        if (b2b) begin
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        for (int i = 0; i < FL; i++) begin
            for (int j = 0; j < gap; j++) begin
                @(negedge clk);
                if (j > 0 && ready_mode == 0) check("gap_valid_low", 32'(bus.o_symbol_valid), 32'd0);
                @(posedge clk);
                #1;
            end
            drive_bit(bits[i], start_mid && (i == 2));
        end
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < TMO; t++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail_event("frame_done");
        check("queue_empty_after_frame", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [FL-1:0] bits;
        int            gap;
        bit            b2b;

        bus.i_data_valid = 1'b0;
        bus.i_data_bit   = 1'b0;

        #3;
        check("rst_symbol_valid", 32'(bus.o_symbol_valid), 32'd0);
        check("rst_symbol", 32'(bus.o_symbol), 32'd0);
        check("rst_data_ready", 32'(bus.o_data_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fsm", 32'(dbg_fsm), 32'(ENC_IDLE));
        check("rst_state", 32'(dbg_s), 32'(S0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed frame 1,0,1,1 with full throughput, then toggled ready, then gapped input.
        ready_mode = 0;
        push_golden_1011();
        send_frame(4'b1101, 0, 1'b0, 1'b0, 1'b0);
        wait_done();

        ready_mode = 1;
        push_golden_1011();
        send_frame(4'b1101, 0, 1'b0, 1'b0, 1'b0);
        wait_done();

        ready_mode = 0;
        push_golden_1011();
        send_frame(4'b1101, 2, 1'b0, 1'b0, 1'b0);
        wait_done();

        // Valid while idle must not be taken.
        @(posedge clk);
        #1;
        bus.i_data_valid = 1'b1;
        bus.i_data_bit   = 1'b1;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            check("idle_data_ready_low", 32'(bus.o_data_ready), 32'd0);
            check("idle_busy_low", 32'(busy), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.i_data_valid = 1'b0;

        // i_start pulsed mid-DATA is ignored.
        ready_mode = 2;
        bits = FL'($urandom);
        send_frame(bits, 0, 1'b1, 1'b0, 1'b1);
        wait_done();

        // Reset after the second symbol, then an all-zero frame.
        ready_mode = 0;
        push_model(4'b1011);
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < FL; i++) begin
            drive_bit(1'b1, 1'b0);
            if (mon_cnt >= 2) break;
        end
        check("busy_mid_frame", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_symbol_valid", 32'(bus.o_symbol_valid), 32'd0);
        check("midrst_symbol", 32'(bus.o_symbol), 32'd0);
        check("midrst_data_ready", 32'(bus.o_data_ready), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(4'b0000, 0, 1'b0, 1'b0, 1'b1);
        wait_done();

        // Back-to-back frames started in the o_done cycle.
        bits = FL'($urandom);
        send_frame(bits, 0, 1'b0, 1'b0, 1'b1);
        wait_done();
        for (int f = 0; f < 2; f++) begin
            b2b_armed = 1'b1;
            bits = FL'($urandom);
            send_frame(bits, 0, 1'b0, 1'b1, 1'b1);
            wait_done();
        end

        // Randomized frames: data, gaps, downstream back-pressure, occasional back-to-back.
        for (int f = 0; f < 12; f++) begin
            bits       = FL'($urandom);
            gap        = $urandom_range(0, 2);
            ready_mode = $urandom_range(0, 2);
            b2b        = 1'($urandom_range(0, 1));
            if (b2b && gap == 0) b2b_armed = 1'b1;
            send_frame(bits, gap, 1'b0, b2b, 1'b1);
            wait_done();
        end

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL global_timeout: bench did not complete (cycle %0d)", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
